// File: rtl/rx_session_ctrl_pkg.sv
// rx_session_pkg: session controller state/verdict types and default constants.
package rx_session_pkg;
    typedef enum logic [1:0] {FLUSH, IDLE, RECV, HOLD} state_e;
    typedef enum logic [1:0] {NONE, ACCEPT, REJECT} verdict_e;
    localparam int GAP_CYCLES_DEF = 12000;
    localparam int HOLD_CYCLES_DEF = 6000000;
    localparam int MAX_LEN_DEF = 16;
    localparam logic [7:0] DELIM_DEF = 8'h0A;
endpackage

// File: rtl/rx_session_ctrl_if.sv
// rx_session_ctrl_if: receive-side, datapath and LED signals of the session controller.
interface rx_session_ctrl_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic fsm_accept;
    logic fsm_reject;
    logic [7:0] fwd_data;
    logic fwd_valid;
    logic dp_rst;
    logic result_accept;
    logic result_reject;
    logic busy;
    logic [15:0] accept_count;
    logic [15:0] reject_count;
    modport master (
        output rx_data, rx_valid, fsm_accept, fsm_reject,
        input fwd_data, fwd_valid, dp_rst, result_accept, result_reject, busy, accept_count, reject_count
    );
    modport slave (
        input rx_data, rx_valid, fsm_accept, fsm_reject,
        output fwd_data, fwd_valid, dp_rst, result_accept, result_reject, busy, accept_count, reject_count
    );
endinterface

// File: rtl/rx_session_ctrl_session_timer.sv
// session_timer: loadable down-counter that parks at zero; expired_o flags zero.
module session_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= load_i ? val_i : cnt_q - W'(cnt_q != '0);
    end
    assign expired_o = cnt_q == '0;
endmodule

// File: rtl/rx_session_ctrl.sv
// rx_session_ctrl: frames UART bytes into sessions and latches verdicts for display.
// RX_SESSION_STATS_EN builds the saturating accept/reject counters; otherwise counts read 0.
module rx_session_ctrl
    import rx_session_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter logic [7:0] DELIM = DELIM_DEF
) (
    input logic clk,
    input logic rst,
    rx_session_ctrl_if.slave bus
);
    localparam int TMAX = GAP_CYCLES > HOLD_CYCLES ? GAP_CYCLES : HOLD_CYCLES;
    localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    state_e state_q, state_d;
    verdict_e verdict;
    logic fwd, expired, tload;
    logic [TW-1:0] tval;
    logic [LW-1:0] len_q, len_d;
    logic [7:0] fwd_data_q;
    logic fwd_valid_q, dp_rst_q, acc_q, rej_q, busy_q;
    session_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load_i(tload),
        .val_i(tval),
        .expired_o(expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
            len_q <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q <= 8'h00;
            dp_rst_q <= 1'b1;
            acc_q <= 1'b0;
            rej_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            fwd_valid_q <= fwd;
            if (fwd) fwd_data_q <= bus.rx_data;
            dp_rst_q <= state_d == FLUSH;
            busy_q <= state_d != IDLE;
            acc_q <= verdict == ACCEPT || (acc_q && state_d == HOLD);
            rej_q <= verdict == REJECT || (rej_q && state_d == HOLD);
        end
    end
    // A verdict in RECV swallows any byte arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        verdict = NONE;
        fwd = 1'b0;
        case (state_q)
            FLUSH: state_d = IDLE;
            IDLE: begin
                fwd = bus.rx_valid && bus.rx_data != DELIM;
                state_d = fwd ? RECV : IDLE;
            end
            RECV: begin
                verdict = bus.fsm_accept ? ACCEPT :
                          bus.fsm_reject ? REJECT :
                          (bus.rx_valid && (bus.rx_data == DELIM || len_q == LW'(MAX_LEN))) ? REJECT :
                          (!bus.rx_valid && expired) ? REJECT : NONE;
                fwd = verdict == NONE && bus.rx_valid;
                state_d = verdict == NONE ? RECV : HOLD;
            end
            HOLD: state_d = expired ? FLUSH : HOLD;
            default: state_d = FLUSH;
        endcase
    end
    // The timer is the gap timer while receiving and the hold timer once a verdict lands.
    always_comb begin
        len_d = fwd ? (state_q == IDLE ? LW'(1) : len_q + LW'(1)) : len_q;
        tload = fwd || (state_q == RECV && state_d == HOLD);
        tval = state_d == HOLD ? TW'(HOLD_CYCLES - 1) : TW'(GAP_CYCLES - 1);
    end
    assign bus.fwd_data = fwd_data_q;
    assign bus.fwd_valid = fwd_valid_q;
    assign bus.dp_rst = dp_rst_q;
    assign bus.result_accept = acc_q;
    assign bus.result_reject = rej_q;
    assign bus.busy = busy_q;
`ifdef RX_SESSION_STATS_EN
    logic [15:0] acc_cnt_q, rej_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= 16'h0000;
            rej_cnt_q <= 16'h0000;
        end else begin
            if (verdict == ACCEPT && acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
            if (verdict == REJECT && rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
        end
    end
    assign bus.accept_count = acc_cnt_q;
    assign bus.reject_count = rej_cnt_q;
`else
    assign bus.accept_count = 16'h0000;
    assign bus.reject_count = 16'h0000;
`endif
endmodule

// File: doc/rx_session_ctrl.md
# rx_session_ctrl

Session controller for the serial receive path: it sits between the UART receiver and the XOR cipher and grammar FSM, forwarding received bytes into the datapath and framing them into sessions. It handles delimiter, inter-byte timeout and overlength aborts, resets the cipher and grammar FSM between sessions, and latches each verdict for a visible hold period. Its outputs drive the board LEDs in place of the raw accept and reject pulses.

## Interface
- `GAP_CYCLES`, 12000: inter-byte timeout in clocks (1 ms at 12 MHz).
- `HOLD_CYCLES`, 6000000: verdict display duration in clocks (0.5 s).
- `MAX_LEN`, 16: maximum bytes forwarded per session.
- `DELIM`, 8'h0A: end-of-session byte. Never forwarded.
- `clk`  in  1  system clock (12 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  single-cycle strobe qualifying `rx_data`.
- `fsm_accept`  in  1  grammar FSM accept.
- `fsm_reject`  in  1  grammar FSM reject.
- `fwd_data`  out  8  byte to the cipher.
- `fwd_valid`  out  1  single-cycle strobe to the cipher.
- `dp_rst`  out  1  synchronous reset to the cipher and grammar FSM.
- `result_accept`  out  1  held high for the accept hold period.
- `result_reject`  out  1  held high for the reject hold period.
- `busy`  out  1  high in RECV, HOLD and FLUSH.
- `accept_count`  out  16  sessions accepted.
- `reject_count`  out  16  sessions rejected.

## Operation
- States: FLUSH, IDLE, RECV, HOLD.
- Reset: state FLUSH, `dp_rst`=1, every other output 0, counters 0, `fwd_data`=0.
- FLUSH: `dp_rst`=1 for exactly one cycle, then IDLE.
- IDLE:
  - `rx_valid` with a byte other than `DELIM`: forward the byte, len:=1, clear the gap counter, go to RECV.
  - `DELIM` in IDLE: ignored.
- RECV, evaluated in priority order each cycle:
  1. `fsm_accept` → verdict accept, go to HOLD. If `fsm_reject` is also high, accept wins.
  2. `fsm_reject` → verdict reject, go to HOLD.
  3. `rx_valid` with `DELIM` → reject (incomplete session), go to HOLD.
  4. `rx_valid` when len==`MAX_LEN` → byte dropped, reject, go to HOLD.
  5. `rx_valid` otherwise → forward the byte, len++, clear the gap counter.
  6. Gap counter reaches `GAP_CYCLES`-1 with no byte that cycle → reject, go to HOLD.
- A byte arriving in the same cycle as a verdict is dropped, not forwarded.
- HOLD:
  - On entry, the matching result output goes high and the matching counter increments; both counters saturate at 16'hFFFF.
  - Result is held for `HOLD_CYCLES` cycles, then go to FLUSH. The result output drops on entry to FLUSH.
  - All `rx_valid` in HOLD and FLUSH is dropped.
- `rst` mid-session: immediate return to the reset state. There is no verdict and no count change.

## Timing
- Forward latency is 1 cycle. A `rx_valid` in cycle N produces `fwd_valid`=1 in cycle N+1, with `fwd_data` registered.
- `fwd_valid` is never high for two consecutive cycles.
- Verdict latency is 1 cycle. An `fsm_accept` in cycle N gives `result_accept`=1 from cycle N+1 through N+`HOLD_CYCLES`.
- After the hold, `dp_rst`=1 in cycle N+`HOLD_CYCLES`+1. IDLE, able to accept a byte, follows one cycle later.
- Timeout: the reject result rises `GAP_CYCLES`+1 cycles after the last accepted byte's `rx_valid`.
- `result_accept` and `result_reject` are mutually exclusive.
- All outputs are registered.

## Configuration
- `RX_SESSION_STATS_EN` defined: `accept_count` and `reject_count` are implemented as saturating counters.
- `RX_SESSION_STATS_EN` undefined: both count outputs are tied to 16'h0000 and no counter flops are built. All other behaviour is identical.

## Structure
- Package `rx_session_pkg` holds:
  - the state enum (FLUSH, IDLE, RECV, HOLD);
  - the verdict enum (NONE, ACCEPT, REJECT);
  - default constants for `GAP_CYCLES`, `HOLD_CYCLES`, `MAX_LEN` and `DELIM`.
- One sub-module, `session_timer`: a loadable down-counter with an expiry flag. It is time-shared, serving as the gap timer in RECV and the hold timer in HOLD. Its width is clog2(max(`GAP_CYCLES`,`HOLD_CYCLES`)).

## Test plan
Benches shrink the parameters to GAP_CYCLES=20, HOLD_CYCLES=10, MAX_LEN=4.
- Bytes 'C','A','T' 12 cycles apart, with `fsm_accept` pulsed after 'T' → three `fwd_valid` pulses, each 1 cycle after its input. `result_accept` high for 10 cycles, `accept_count`=1, then one `dp_rst` cycle, then `busy`=0.
- 'C', 'X', then `fsm_reject` → `result_reject` for 10 cycles, `reject_count`=1, `accept_count` unchanged.
- 'C' followed by silence → reject asserts 21 cycles after 'C'. `dp_rst` pulses after the hold.
- Five bytes with no verdict → only 4 forwarded; the fifth triggers reject. `DELIM` after 'C','A' → reject with 2 forwarded and `DELIM` never forwarded.
- `rx_valid` coincident with `fsm_accept`; bytes during HOLD; `rst` asserted mid-RECV → none of these bytes is forwarded. After `rst`: counters 0, `dp_rst`=1 for one cycle.
- Both `fsm_accept` and `fsm_reject` high in the same cycle → accept wins. With `RX_SESSION_STATS_EN` undefined, both counts stay 0.
